pattern_scan_ctrl: RTL and testbench

Controller that sequences a programmable serial pattern detector over one bounded input frame. Holds the pattern configuration and runs a start/busy/done handshake with the host. Meters the serial bitstream through a valid/ready pair and accumulates the match count and the position of the first match. Sits between the host/config logic and the serial bit source; replaces hard-wired single-pattern FSM detectors.

---
 rtl/pattern_pkg.sv | 19 +
 rtl/pattern_window_cmp.sv | 48 ++++
 rtl/pattern_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared types and constants for the programmable serial pattern scanner.
package pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int       CFG_LEN_RST = 1;
    localparam logic     CFG_OVL_RST = 1'b1;

    // Width needed to hold a pattern length of 0..max_len.
    function automatic int calc_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/pattern_window_cmp.sv
// History shift register (newest bit at [0]) and a length-masked compare
// of the would-be next history against the programmed pattern.
module pattern_window_cmp
    import pattern_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    localparam int LEN_W   = calc_len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               shift_i,
    input  logic               bit_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    output logic               hit_o
);

    logic [MAX_LEN-1:0] hist_q, hist_d, hist_nxt, mask;

    assign hist_nxt = {hist_q[MAX_LEN-2:0], bit_i};

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_i));
        end
        hit_o = (((hist_nxt ^ pattern_i) & mask) == '0);
    end

    always_comb begin
        hist_d = hist_q;
        if (clr_i) begin
            hist_d = '0;
        end else if (shift_i) begin
            hist_d = hist_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Frame-bounded scan controller: config latch, start/busy/done handshake,
// bit metering, match counting and first-match position capture.
module pattern_scan_ctrl
    import pattern_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = calc_len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               start,
    input  logic [CNT_W-1:0]   frame_len,
    input  logic               in_valid,
    input  logic               in,
    output logic               in_ready,
    output logic               busy,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               first_found,
    output logic [CNT_W-1:0]   first_pos,
    output logic               done
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d, fill_inc;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   flen_q, flen_d, idx_q, idx_d, cnt_q, cnt_d, pos_q, pos_d;
    logic               found_q, found_d, match_q, match_d;
    logic               accept, hit, hit_now;

    assign accept   = in_valid && (state_q == SCAN);
    assign fill_inc = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    assign hit_now  = accept && hit && (fill_inc >= len_q);

    pattern_window_cmp #(.MAX_LEN(MAX_LEN)) u_win (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == ARM),
        .shift_i   (accept),
        .bit_i     (in),
        .pattern_i (pat_q),
        .len_i     (len_q),
        .hit_o     (hit)
    );

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        flen_d  = flen_q;
        idx_d   = idx_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        found_d = found_q;
        pos_d   = pos_q;
        match_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    pat_d = cfg_pattern;
                    ovl_d = cfg_overlap;
                    if (cfg_len == '0) begin
                        len_d = LEN_W'(1);
                    end else if (cfg_len > LEN_W'(MAX_LEN)) begin
                        len_d = LEN_W'(MAX_LEN);
                    end else begin
                        len_d = cfg_len;
                    end
                end
                if (start) begin
                    flen_d = frame_len;
                    // An empty frame skips ARM, so its results are cleared here.
                    if (frame_len == '0) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        found_d = 1'b0;
                        pos_d   = '0;
                    end else begin
                        state_d = ARM;
                    end
                end
            end
            ARM: begin
                idx_d   = '0;
                fill_d  = '0;
                cnt_d   = '0;
                found_d = 1'b0;
                pos_d   = '0;
                state_d = SCAN;
            end
            SCAN: begin
                if (accept) begin
                    idx_d  = idx_q + 1'b1;
                    fill_d = fill_inc;
                    if (hit_now) begin
                        match_d = 1'b1;
                        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                        if (!found_q) begin
                            found_d = 1'b1;
                            pos_d   = idx_q;
                        end
                        if (!ovl_q) begin
                            fill_d = '0;
                        end
                    end
                    if (idx_q + 1'b1 == flen_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= LEN_W'(CFG_LEN_RST);
            ovl_q   <= CFG_OVL_RST;
            flen_q  <= '0;
            idx_q   <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            pos_q   <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            flen_q  <= flen_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            found_q <= found_d;
            pos_q   <= pos_d;
            match_q <= match_d;
        end
    end

    assign in_ready    = (state_q == SCAN);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign match       = match_q;
    assign match_cnt   = cnt_q;
    assign first_found = found_q;
    assign first_pos   = pos_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Table-driven bench for pattern_scan_ctrl with a match scoreboard queue.
module tb_pattern_scan_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cfg_we = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               start = 1'b0;
    logic [CNT_W-1:0]   frame_len = '0;
    logic               in_valid = 1'b0;
    logic               din = 1'b0;
    logic               in_ready, busy, match, first_found, done;
    logic [CNT_W-1:0]   match_cnt, first_pos;

    pattern_scan_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .start       (start),
        .frame_len   (frame_len),
        .in_valid    (in_valid),
        .in          (din),
        .in_ready    (in_ready),
        .busy        (busy),
        .match       (match),
        .match_cnt   (match_cnt),
        .first_found (first_found),
        .first_pos   (first_pos),
        .done        (done)
    );

    always #5 clk = ~clk;

    // stream/mask: bit i is the i-th bit sent / whether it ends a match
    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  len;
        logic        ovl;
        logic [7:0]  flen;
        logic [15:0] stream;
        logic [15:0] mask;
        logic [7:0]  cnt;
        logic [7:0]  fpos;
        logic        found;
        logic        gaps;
        logic        cfgbusy;
        logic        nocfg;
    } vec_t;

    vec_t vecs[10];
    int   total = 0;
    int   bad   = 0;
    logic exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int n);
        vec_t v;
        int   idx, cyc;
        logic acc, seen_done, e;
        v = vecs[n];
        @(negedge clk);
        if (!v.nocfg) begin
            cfg_we = 1'b1; cfg_pattern = v.pat; cfg_len = v.len; cfg_overlap = v.ovl;
            @(negedge clk);
            cfg_we = 1'b0;
        end
        start = 1'b1; frame_len = v.flen;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("v%0d arm busy", n), busy, 1);
        chk($sformatf("v%0d arm in_ready", n), in_ready, 0);
        idx = 0; cyc = 0; seen_done = 1'b0;
        while (!seen_done && cyc < 100) begin
            cyc++;
            if (v.cfgbusy && cyc <= 3) begin
                cfg_we = 1'b1; cfg_pattern = 8'h00; cfg_len = 4'd1; cfg_overlap = 1'b1;
                start = 1'b1; frame_len = 8'd2;
            end else begin
                cfg_we = 1'b0; start = 1'b0;
            end
            in_valid = !v.gaps || (cyc % 2 == 0);
            din = (idx < 16) ? v.stream[idx] : 1'b0;
            acc = in_valid && in_ready;
            if (acc) begin
                exp_q.push_back(v.mask[idx]);
                idx++;
            end
            @(posedge clk);
            #1;
            e = acc ? exp_q.pop_front() : 1'b0;
            chk($sformatf("v%0d match c%0d", n, cyc), match, e);
            chk($sformatf("v%0d done c%0d", n, cyc), done, acc && (idx == int'(v.flen)));
            if (done) seen_done = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0; cfg_we = 1'b0; start = 1'b0;
        if (!seen_done) begin
            total++; bad++;
            $display("FAIL v%0d timeout: done not seen after %0d cycles", n, cyc);
        end
        chk($sformatf("v%0d accepted", n), idx, v.flen);
        chk($sformatf("v%0d match_cnt", n), match_cnt, v.cnt);
        chk($sformatf("v%0d first_found", n), first_found, v.found);
        chk($sformatf("v%0d first_pos", n), first_pos, v.fpos);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d idle busy", n), busy, 0);
        chk($sformatf("v%0d idle done", n), done, 0);
        chk($sformatf("v%0d idle hold cnt", n), match_cnt, v.cnt);
    endtask

    initial begin
        int acc_n, cyc;
        //                pat    len   ovl   flen   stream    mask      cnt   fpos  fnd   gap   cfgb  nocfg
        vecs[0] = '{8'h0D, 4'd4,  1'b1, 8'd7,  16'h005B, 16'h0048, 8'd2, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h0D, 4'd4,  1'b0, 8'd7,  16'h005B, 16'h0008, 8'd1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h0D, 4'd4,  1'b1, 8'd4,  16'h000B, 16'h0008, 8'd1, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h01, 4'd0,  1'b1, 8'd5,  16'h000D, 16'h000D, 8'd3, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h0D, 4'd4,  1'b1, 8'd5,  16'h0000, 16'h0000, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 4'd3,  1'b0, 8'd6,  16'h0000, 16'h0024, 8'd2, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 4'd3,  1'b1, 8'd6,  16'h0000, 16'h003C, 8'd4, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 4'd15, 1'b1, 8'd10, 16'h03FF, 16'h0380, 8'd3, 8'd7, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{8'h00, 4'd1,  1'b1, 8'd3,  16'h0000, 16'h0007, 8'd3, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{8'h0D, 4'd4,  1'b1, 8'd7,  16'h005B, 16'h0048, 8'd2, 8'd3, 1'b1, 1'b0, 1'b1, 1'b0};

        #12;
        chk("rst busy", busy, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst match", match, 0);
        chk("rst done", done, 0);
        chk("rst match_cnt", match_cnt, 0);
        chk("rst first_found", first_found, 0);
        chk("rst first_pos", first_pos, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i);

        // empty frame: straight to DONE, results cleared, nothing consumed
        @(negedge clk);
        start = 1'b1; frame_len = 8'd0; in_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("f0 done", done, 1);
        chk("f0 busy", busy, 1);
        chk("f0 in_ready", in_ready, 0);
        chk("f0 match_cnt", match_cnt, 0);
        chk("f0 first_found", first_found, 0);
        @(posedge clk);
        #1;
        chk("f0 idle done", done, 0);
        chk("f0 idle busy", busy, 0);
        chk("f0 idle in_ready", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;

        // async reset after two accepted bits
        cfg_we = 1'b1; cfg_pattern = 8'h0D; cfg_len = 4'd4; cfg_overlap = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b1; frame_len = 8'd7;
        @(negedge clk);
        start = 1'b0; acc_n = 0; cyc = 0;
        while (acc_n < 2 && cyc < 20) begin
            cyc++;
            in_valid = 1'b1; din = 1'b1;
            if (in_ready) acc_n++;
            @(negedge clk);
        end
        chk("rstmid accepted", acc_n, 2);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rstmid busy", busy, 0);
        chk("rstmid in_ready", in_ready, 0);
        chk("rstmid match", match, 0);
        chk("rstmid done", done, 0);
        chk("rstmid match_cnt", match_cnt, 0);
        chk("rstmid first_pos", first_pos, 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("rstmid no done", done, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstrel no done", done, 0);
        chk("rstrel busy", busy, 0);

        run_vec(8);
        run_vec(9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
